// File: rtl/enc_pkg.sv
// Shared constants and helpers for the priority encoder pipeline.
// Round-robin arbitration is selected by defining PRIO_ENCODER_RR_EN.
package enc_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int MAX_WIDTH     = 256;

    // Width of an index into an n-bit vector, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic at_least_two(input logic [MAX_WIDTH-1:0] v);
        return |(v & (v - MAX_WIDTH'(1)));
    endfunction

endpackage

// File: rtl/prio_scan.sv
// Circular first-set-bit search: scans start, start+1, ... WIDTH-1, then 0 ...
// Used for both arbitration modes (fixed priority feeds it a bit-reversed vector).
module prio_scan
    import enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OUT_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [OUT_W-1:0] start,
    output logic [OUT_W-1:0] index,
    output logic             found
);

    // One spare bit so start + offset cannot overflow before the wrap.
    logic [OUT_W:0] pos_s;

    // Walk every offset from start and keep the first hit.
    always_comb begin
        index = '0;
        found = 1'b0;
        pos_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pos_s = {1'b0, start} + (OUT_W+1)'(i);
            if (pos_s >= (OUT_W+1)'(WIDTH)) begin
                pos_s = pos_s - (OUT_W+1)'(WIDTH);
            end else begin
                pos_s = pos_s;
            end
            if (!found && vec[pos_s[OUT_W-1:0]]) begin
                found = 1'b1;
                index = pos_s[OUT_W-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with valid/ready handshakes on both sides.
// Define PRIO_ENCODER_RR_EN for round-robin arbitration instead of highest-index-wins.
module prio_encoder_pipe
    import enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           input_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   out,
    output logic                       out_any,
    output logic                       out_multi
);

    localparam int OUT_W = $clog2(WIDTH);

    logic             in_fire_s;
    logic             out_fire_s;
    logic             multi_s;
    logic [WIDTH-1:0] scan_vec_s;
    logic [OUT_W-1:0] scan_start_s;
    logic [OUT_W-1:0] scan_idx_s;
    logic             scan_found_s;
    logic [OUT_W-1:0] winner_s;

    assign in_ready   = enable && (!out_valid || out_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;
    assign multi_s    = at_least_two(MAX_WIDTH'(input_vec));

    prio_scan #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_scan (
        .vec   (scan_vec_s),
        .start (scan_start_s),
        .index (scan_idx_s),
        .found (scan_found_s)
    );

`ifdef PRIO_ENCODER_RR_EN
    logic [OUT_W-1:0] ptr;

    assign scan_vec_s   = input_vec;
    assign scan_start_s = ptr;
    assign winner_s     = scan_idx_s;

    // Advance the pointer past the winner; explicit wrap covers non-power-of-two widths.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (in_fire_s && scan_found_s) begin
            if (scan_idx_s == OUT_W'(WIDTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= scan_idx_s + OUT_W'(1);
            end
        end else begin
            ptr <= ptr;
        end
    end
`else
    // Reverse the vector so the circular scan from 0 finds the highest set index.
    always_comb begin
        scan_vec_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scan_vec_s[i] = input_vec[WIDTH-1-i];
        end
    end

    assign scan_start_s = '0;
    assign winner_s     = OUT_W'(WIDTH - 1) - scan_idx_s;
`endif

    // Output stage: load on input handshake, clear on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_any   <= 1'b0;
            out_multi <= 1'b0;
        end else if (in_fire_s) begin
            out_valid <= 1'b1;
            out       <= scan_found_s ? winner_s : '0;
            out_any   <= scan_found_s;
            out_multi <= multi_s;
        end else if (out_fire_s) begin
            out_valid <= 1'b0;
            out       <= out;
            out_any   <= out_any;
            out_multi <= out_multi;
        end else begin
            out_valid <= out_valid;
            out       <= out;
            out_any   <= out_any;
            out_multi <= out_multi;
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed self-checking bench for prio_encoder_pipe (fixed or round-robin build).
module tb_prio_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] input_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out;
    logic        out_any;
    logic        out_multi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_vec (input_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_any   (out_any),
        .out_multi (out_multi)
    );

`ifdef PRIO_ENCODER_RR_EN
    logic       in_valid5;
    logic       in_ready5;
    logic [4:0] input_vec5;
    logic       out_valid5;
    logic [2:0] out5;
    logic       out_any5;
    logic       out_multi5;

    prio_encoder_pipe #(.WIDTH(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .input_vec (input_vec5),
        .out_valid (out_valid5),
        .out_ready (1'b1),
        .out       (out5),
        .out_any   (out_any5),
        .out_multi (out_multi5)
    );
`endif

    typedef struct {
        logic [15:0] vec;
        logic [3:0]  exp_out;
        logic        exp_any;
        logic        exp_multi;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[1] = '{16'h0008, 4'd3,  1'b1, 1'b0};
        tbl[2] = '{16'h0005, 4'd2,  1'b1, 1'b1};
        tbl[3] = '{16'h0210, 4'd9,  1'b1, 1'b1};
        tbl[4] = '{16'h2020, 4'd13, 1'b1, 1'b1};
        tbl[5] = '{16'h0040, 4'd6,  1'b1, 1'b0};
        tbl[6] = '{16'h0680, 4'd10, 1'b1, 1'b1};

        rst       = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_vec = 16'h0000;
`ifdef PRIO_ENCODER_RR_EN
        in_valid5  = 1'b0;
        input_vec5 = 5'h00;
`endif
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out",   32'(out),       32'd0);
        check("rst_any",   32'(out_any),   32'd0);
        check("rst_multi", 32'(out_multi), 32'd0);

        rst = 1'b0;
        tick();
        check("post_rst_ready_en0", 32'(in_ready), 32'd0);
        enable = 1'b1;
        #1;
        check("post_rst_ready_en1", 32'(in_ready), 32'd1);

`ifndef PRIO_ENCODER_RR_EN
        // Streaming table with the consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            input_vec = tbl[i].vec;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d_out", i),   32'(out),       32'(tbl[i].exp_out));
            check($sformatf("tbl%0d_any", i),   32'(out_any),   32'(tbl[i].exp_any));
            check($sformatf("tbl%0d_multi", i), 32'(out_multi), 32'(tbl[i].exp_multi));
        end
`endif

        // Drain: output handshake alone clears out_valid.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure holds the result and blocks input.
        input_vec = 16'h0008;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        input_vec = 16'h0040;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_out", c),   32'(out),       32'd3);
            check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_ready", c), 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_next_out",   32'(out),       32'd6);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // Enable low blocks acceptance.
        enable    = 1'b0;
        in_valid  = 1'b1;
        input_vec = 16'h8000;
        #1;
        check("en0_ready", 32'(in_ready), 32'd0);
        tick();
        check("en0_valid_a", 32'(out_valid), 32'd0);
        tick();
        check("en0_valid_b", 32'(out_valid), 32'd0);
        enable = 1'b1;
        tick();
        check("en1_valid", 32'(out_valid), 32'd1);
        check("en1_out",   32'(out),       32'd15);
        in_valid = 1'b0;
        tick();

        // Enable low still lets a pending result drain.
        in_valid  = 1'b1;
        input_vec = 16'h0004;
        out_ready = 1'b0;
        tick();
        enable    = 1'b0;
        out_ready = 1'b1;
        tick();
        check("en0_drain_valid", 32'(out_valid), 32'd0);
        enable   = 1'b1;
        in_valid = 1'b0;

        // Reset mid-operation discards the pending result and beats a handshake.
        input_vec = 16'h0200;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        check("pre_rst_out", 32'(out), 32'd9);
        input_vec = 16'h0108;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_out",   32'(out),       32'd0);
        check("midrst_multi", 32'(out_multi), 32'd0);
`ifdef PRIO_ENCODER_RR_EN
        check("midrst_ptr", 32'(dut.ptr), 32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

`ifdef PRIO_ENCODER_RR_EN
        // Round-robin rotation over an all-ones vector.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        input_vec = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d_out", k),   32'(out),       32'(k));
            check($sformatf("rr%0d_multi", k), 32'(out_multi), 32'd1);
        end
        check("rr_ptr4", 32'(dut.ptr), 32'd4);
        input_vec = 16'h0000;
        tick();
        check("rr_zero_any", 32'(out_any),  32'd0);
        check("rr_zero_ptr", 32'(dut.ptr),  32'd4);
        input_vec = 16'h0001;
        tick();
        check("rr_wrap_out", 32'(out),      32'd0);
        check("rr_wrap_ptr", 32'(dut.ptr),  32'd1);
        in_valid = 1'b0;
        tick();

        // Non-power-of-two width wraps the pointer from 4 back to 0.
        in_valid5  = 1'b1;
        input_vec5 = 5'h10;
        tick();
        check("w5_a_out", 32'(out5),      32'd4);
        check("w5_a_ptr", 32'(dut5.ptr),  32'd0);
        input_vec5 = 5'h1F;
        tick();
        check("w5_b_out",   32'(out5),       32'd0);
        check("w5_b_multi", 32'(out_multi5), 32'd1);
        check("w5_b_ptr",   32'(dut5.ptr),   32'd1);
        in_valid5 = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder_pipe.md
PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of request bits (legal range 2..256, not restricted to powers of two).
REQ-002 The block SHALL have localparam OUT_W, set to $clog2(WIDTH), giving the encoded index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: when low, no new vector is accepted.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input_vec is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept input_vec this cycle.
REQ-008 The block SHALL have port input_vec, input, WIDTH bits: request vector.
REQ-009 The block SHALL have port out_valid, output, 1 bit: registered result present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 The block SHALL have port out, output, OUT_W bits: encoded index of the winning bit.
REQ-012 The block SHALL have port out_any, output, 1 bit: at least one bit was set.
REQ-013 The block SHALL have port out_multi, output, 1 bit: two or more bits were set.

Function
REQ-014 in_ready SHALL equal enable && (!out_valid || out_ready), i.e. purely combinational with no dependence on in_valid.
REQ-015 An input handshake (in_valid && in_ready) at edge N SHALL load out, out_any and out_multi, and set out_valid at edge N (1-cycle latency).
REQ-016 While out_valid && !out_ready, out, out_any and out_multi SHALL hold stable.
REQ-017 On an output handshake with no simultaneous input handshake, out_valid SHALL clear.
REQ-018 Simultaneous output and input handshakes SHALL replace the result with no bubble, giving full throughput.
REQ-019 Fixed-priority mode SHALL make the highest set index win (0x0210 -> 9).
REQ-020 An all-zero vector SHALL be accepted normally and produce out=0, out_any=0, out_multi=0.
REQ-021 enable low SHALL block acceptance only; a pending result SHALL still drain via out_ready.
REQ-022 out_multi SHALL be 1 iff the popcount of the vector is at least 2.

Reset
REQ-023 On rst high at a rising edge, out_valid, out, out_any, out_multi and the round-robin pointer SHALL all reset to 0.
REQ-024 rst SHALL take priority over any simultaneous handshake, and a result pending mid-operation SHALL be discarded.
REQ-025 In the cycle after rst deasserts, in_ready SHALL equal enable.

Configuration
REQ-026 Macro PRIO_ENCODER_RR_EN, when defined, SHALL replace fixed priority with round-robin arbitration.
REQ-027 With PRIO_ENCODER_RR_EN defined, an OUT_W-bit pointer ptr SHALL exist, and the winner SHALL be the first set bit scanning ptr, ptr+1, ... WIDTH-1, then wrapping to 0.
REQ-028 With PRIO_ENCODER_RR_EN defined, on an input handshake with a nonzero vector and winner k, ptr SHALL update to (k+1) mod WIDTH; a zero vector SHALL leave ptr unchanged.
REQ-029 With PRIO_ENCODER_RR_EN defined, ptr SHALL wrap correctly for non-power-of-two WIDTH and SHALL never exceed WIDTH-1.
REQ-030 With PRIO_ENCODER_RR_EN undefined, no pointer SHALL exist and REQ-019 behaviour SHALL apply.

Structure
REQ-031 Package enc_pkg SHALL hold the default WIDTH constant, a popcount-at-least-2 function and the index-width helper.
REQ-032 The combinational search SHALL be a sub-module prio_scan (inputs vector and start index; outputs index and found), instantiated once.

Verification
REQ-033 Fixed mode, WIDTH=16, out_ready=1: inputs 0x0000, 0x0008, 0x0005, 0x0210, 0x2020, 0x0040, 0x0680 SHALL give out = 0, 3, 2, 9, 13, 6, 10 one cycle later, with out_any = 0, 1, 1, 1, 1, 1, 1 and out_multi = 0, 0, 1, 1, 1, 0, 1.
REQ-034 Backpressure: with out_ready=0 for 3 cycles after accepting 0x0008, out SHALL hold 3 and in_ready SHALL be 0; when out_ready rises, a queued 0x0040 SHALL give 6 on the next cycle.
REQ-035 Enable: with enable=0 and in_valid=1 (0x8000), in_ready SHALL be 0 and no result appears; when enable rises, out SHALL be 15 one cycle later.
REQ-036 Reset mid-operation: rst asserted while out_valid=1 (out=9) SHALL make out_valid=0, out=0 and ptr=0 on the next cycle.
REQ-037 RR_EN, WIDTH=16: 0xFFFF presented four times SHALL give out 0, 1, 2, 3; then 0x0001 with ptr=4 SHALL give 0 via wrap.
REQ-038 RR_EN, WIDTH=5: 0x10 then 0x1F SHALL give 4, then 0 (ptr wraps from 4 to 0).
